// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : execute_unit
//  Description : Single-issue 16-bit execute stage. ALU ops complete at the
//                accepting edge and write back one cycle later; MUL runs a
//                16-cycle LSB-first shift-add before write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [1:0]  dest,
    output logic        busy,
    output logic [15:0] alu_result,
    output logic [1:0]  store_at,
    output logic        write_enable,
    output logic        zero_flag,
    output logic        carry_flag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [4:0] C_MUL_LAST = 5'd15;

    logic [1:0]  r_state;
    logic [1:0]  r_dest;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [15:0] r_mplier;

    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [16:0] w_shl;
    logic [16:0] w_shr;
    logic [15:0] w_alu;
    logic        w_carry;
    logic [31:0] w_acc_next;

    // Single-cycle ALU; the 17-bit intermediates carry the flag bit in their
    // spare position (carry/borrow at bit 16, SHL out at bit 16, SHR out at bit 0).
    always_comb begin
        w_sum   = {1'b0, operand_a} + {1'b0, operand_b};
        w_diff  = {1'b0, operand_a} - {1'b0, operand_b};
        w_shl   = {1'b0, operand_a} << operand_b[3:0];
        w_shr   = {operand_a, 1'b0} >> operand_b[3:0];
        w_alu   = 16'h0000;
        w_carry = 1'b0;
        case (opcode)
            OP_ADD: begin w_alu = w_sum[15:0];  w_carry = w_sum[16];  end
            OP_SUB: begin w_alu = w_diff[15:0]; w_carry = w_diff[16]; end
            OP_AND: w_alu = operand_a & operand_b;
            OP_OR:  w_alu = operand_a | operand_b;
            OP_XOR: w_alu = operand_a ^ operand_b;
            OP_SHL: begin w_alu = w_shl[15:0];  w_carry = w_shl[16];  end
            OP_SHR: begin w_alu = w_shr[16:1];  w_carry = w_shr[0];   end
            default: begin w_alu = 16'h0000; w_carry = 1'b0; end
        endcase
    end

    // Accumulator value after consuming the current multiplier LSB.
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
    end

    // Control FSM plus result/flag registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dest     <= 2'b00;
            r_cnt      <= 5'd0;
            r_acc      <= 32'd0;
            r_mcand    <= 32'd0;
            r_mplier   <= 16'h0000;
            alu_result <= 16'h0000;
            store_at   <= 2'b00;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (opcode == OP_MUL) begin
                            r_mcand  <= {16'h0000, operand_a};
                            r_mplier <= operand_b;
                            r_dest   <= dest;
                            r_acc    <= 32'd0;
                            r_cnt    <= 5'd0;
                            r_state  <= ST_MUL;
                        end else begin
                            alu_result <= w_alu;
                            store_at   <= dest;
                            zero_flag  <= (w_alu == 16'h0000);
                            carry_flag <= w_carry;
                            r_state    <= ST_WB;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[30:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[15:1]};
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == C_MUL_LAST) begin
                        alu_result <= w_acc_next[15:0];
                        store_at   <= r_dest;
                        zero_flag  <= (w_acc_next[15:0] == 16'h0000);
                        carry_flag <= (w_acc_next[31:16] != 16'h0000);
                        r_state    <= ST_WB;
                    end
                end
                ST_WB:   r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign write_enable = (r_state == ST_WB);

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_unit
//  Description : Scoreboard bench for execute_unit: driver pushes expected
//                write-backs from an arithmetic reference model, monitor pops
//                and compares on every write_enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic [15:0] operand_a = 16'h0;
    logic [15:0] operand_b = 16'h0;
    logic [1:0]  dest = 2'd0;
    logic        busy;
    logic [15:0] alu_result;
    logic [1:0]  store_at;
    logic        write_enable;
    logic        zero_flag;
    logic        carry_flag;

    execute_unit dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .dest(dest),
        .busy(busy), .alu_result(alu_result), .store_at(store_at),
        .write_enable(write_enable), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [1:0]  dst;
        logic        z;
        logic        c;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc = 0;
    int   busy_from = 1;
    int   busy_until = -1;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: direct arithmetic on the operands, no cycle detail.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [1:0] d);
        exp_t        e;
        logic [31:0] ua, ub, full;
        int          s;
        ua = {16'h0, a};
        ub = {16'h0, b};
        s  = int'(b & 16'h000F);
        full = 32'd0;
        e.c = 1'b0;
        case (op)
            3'd0: begin full = ua + ub; e.c = (full > 32'h0000FFFF); end
            3'd1: begin full = ua - ub; e.c = (ua < ub); end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: begin full = ua << s; e.c = (s != 0) ? ((ua >> (16 - s)) & 32'd1) != 0 : 1'b0; end
            3'd6: begin full = ua >> s; e.c = (s != 0) ? ((ua >> (s - 1)) & 32'd1) != 0 : 1'b0; end
            default: begin full = ua * ub; e.c = (full >> 16) != 0; end
        endcase
        e.res = full[15:0];
        e.z   = (e.res == 16'h0);
        e.dst = d;
        e.due = 0;
        return e;
    endfunction

    // Monitor: checks busy every cycle, pops on write_enable, else checks hold.
    always @(negedge clk) begin
        exp_t e;
        chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from) && (cyc <= busy_until)});
        if (write_enable) begin
            if (q.size() == 0) begin
                chk("unexpected_write_enable", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("we_cycle", cyc, e.due);
                chk("alu_result", {16'd0, alu_result}, {16'd0, e.res});
                chk("store_at", {30'd0, store_at}, {30'd0, e.dst});
                chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
                chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
                held = e;
            end
        end else begin
            if (q.size() != 0 && q[0].due < cyc) begin
                chk("missing_write_enable", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            chk("hold", {alu_result, store_at, zero_flag, carry_flag, 12'd0},
                        {held.res, held.dst, held.z, held.c, 12'd0});
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after
    // the accepting edge.
    task automatic accept(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] d);
        exp_t e;
        e = model(op, a, b, d);
        opcode = op; operand_a = a; operand_b = b; dest = d; start = 1'b1;
        @(posedge clk); #1;
        e.due = (op == 3'd7) ? cyc + 16 : cyc;
        busy_from  = cyc;
        busy_until = e.due;
        q.push_back(e);
    endtask

    // Spend n cycles with scrambled inputs and random start pulses.
    task automatic scramble(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom); opcode = 3'($urandom);
            operand_a = 16'($urandom); operand_b = 16'($urandom); dest = 2'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] d);
        accept(op, a, b, d);
        scramble((op == 3'd7) ? 17 : 1);
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom % 6)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        held = '{16'h0, 2'd0, 1'b0, 1'b0, 0};
        reset = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_alu_result", {16'd0, alu_result}, 32'd0);
        chk("reset_flags", {29'd0, write_enable, zero_flag, carry_flag}, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        issue(3'd0, 16'hFFFF, 16'h0001, 2'b10);   // ADD wrap
        issue(3'd1, 16'h0003, 16'h0005, 2'b01);   // SUB borrow
        issue(3'd7, 16'h0100, 16'h0100, 2'b11);   // MUL overflow to high half
        issue(3'd5, 16'h8001, 16'h0001, 2'b00);   // SHL
        issue(3'd6, 16'h0001, 16'h0000, 2'b01);   // SHR by 0
        issue(3'd0, 16'h1234, 16'h0001, 2'b10);   // ADD then XOR back-to-back
        issue(3'd4, 16'h00FF, 16'h0F0F, 2'b11);

        // Reset during MUL cycle 8, with start also high.
        accept(3'd7, 16'h1234, 16'h5678, 2'b10);
        scramble(7);
        reset = 1'b1; start = 1'b1; opcode = 3'd0;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        q.delete();
        held = '{16'h0, 2'd0, 1'b0, 1'b0, 0};
        busy_until = -1;
        @(negedge clk);
        chk("abort_outputs", {alu_result, store_at, busy, write_enable, zero_flag, carry_flag, 10'd0}, 32'd0);
        @(posedge clk); #1;
        issue(3'd0, 16'h0002, 16'h0003, 2'b01);

        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom), rnd_val(), rnd_val(), 2'($urandom));
            if ($urandom % 3 == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed at 16-bit data, 2-bit register index, 3-bit opcode.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 SHALL have port: opcode  input  3  operation select, encoding per REQ-013.
REQ-006 SHALL have port: operand_a  input  16  first source operand.
REQ-007 SHALL have port: operand_b  input  16  second source operand / shift amount.
REQ-008 SHALL have port: dest  input  2  destination register index (00=A, 01=B, 10=C, 11=D).
REQ-009 SHALL have port: busy  output  1  high while an accepted operation is in progress (MUL or WB state).
REQ-010 SHALL have port: alu_result  output  16  registered result, feeds the register file write data.
REQ-011 SHALL have port: store_at  output  2  registered destination index, feeds the register file select.
REQ-012 SHALL have port: write_enable  output  1  one-cycle write strobe to the register file; zero_flag / carry_flag  output  1 each  registered status.

Function
REQ-013 SHALL decode opcode: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL a by b[3:0], 110 SHR logical a by b[3:0], 111 MUL (low 16 bits of a*b).
REQ-014 SHALL implement FSM states IDLE, MUL, WB; reset state IDLE.
REQ-015 SHALL, in IDLE with start=1 and opcode!=111: latch opcode/dest, compute result, load alu_result and store_at at that edge, go to WB.
REQ-016 SHALL, in IDLE with start=1 and opcode=111: latch operands/dest, clear 32-bit accumulator and 5-bit counter, go to MUL.
REQ-017 SHALL perform MUL as shift-add, one multiplier bit per cycle, LSB first, exactly 16 cycles in MUL; then load alu_result = accumulator[15:0], go to WB.
REQ-018 SHALL in WB assert write_enable=1 for exactly one cycle, then return to IDLE; write_enable=0 in every other state.
REQ-019 SHALL give latency: non-MUL write_enable high in cycle 1 after the accepting edge; MUL write_enable high in cycle 17 after the accepting edge.
REQ-020 SHALL ignore start while busy=1; operand/opcode/dest changes during MUL or WB SHALL NOT affect the result.
REQ-021 SHALL accept a new start in the IDLE cycle immediately following WB (back-to-back throughput: one non-MUL op per 2 cycles).
REQ-022 SHALL compute ADD/SUB modulo 2^16; carry_flag = carry-out for ADD, borrow (a<b unsigned) for SUB.
REQ-023 SHALL set carry_flag for SHL = last bit shifted out (0 if shift=0); SHR = last bit shifted out (0 if shift=0); AND/OR/XOR = 0; MUL = 1 iff product[31:16]!=0.
REQ-024 SHALL set zero_flag = (result==16'h0000); both flags updated at the same edge alu_result is loaded and held until the next operation.
REQ-025 SHALL hold alu_result and store_at stable from load until the next accepted operation loads them.

Reset
REQ-026 SHALL, with reset=1 at a rising edge, force state IDLE, busy=0, write_enable=0, alu_result=16'h0000, store_at=2'b00, zero_flag=0, carry_flag=0, counter=0, accumulator=0.
REQ-027 SHALL abort any in-progress MUL or WB on reset without emitting write_enable; reset has priority over start in the same cycle.

Verification
REQ-028 SHALL cover: ADD a=16'hFFFF, b=16'h0001, dest=10 -> next cycle write_enable=1, alu_result=0000, store_at=10, zero=1, carry=1.
REQ-029 SHALL cover: SUB a=0003, b=0005 -> alu_result=FFFE, carry=1, zero=0; write_enable high exactly one cycle.
REQ-030 SHALL cover: MUL a=0100, b=0100, dest=11 -> busy for 17 cycles, write_enable in cycle 17, alu_result=0000, zero=1, carry=1; start pulses during MUL ignored.
REQ-031 SHALL cover: SHL a=8001, b=0001 -> alu_result=0002, carry=1; SHR a=0001, b=0000 -> alu_result=0001, carry=0.
REQ-032 SHALL cover: reset asserted in MUL cycle 8 -> no write_enable, all outputs zero next cycle, new ADD 0002+0003 then gives 0005.
REQ-033 SHALL cover: back-to-back ADD then XOR (a=00FF, b=0F0F) -> write_enable in cycles 1 and 3, second alu_result=0FF0.
